ads5404_bringup_ctrl: RTL and testbench
=======================================

// Module: ads5404_bringup_ctrl
// PURPOSE
//  Power-up/recovery sequencer for one ads5404_top instance. Runs on a free-running system clock.
//  Sequence: drive user_rst, wait for a stable PLL lock (with timeout and retry), load IDELAY taps
//  lane by lane, pulse user_sync, then hold RUN. Restarts on PLL lock loss; reports ready/error.
// PARAMETERS
//  RST_CYCLES    64     cycles user_rst held high in RESET (>=1)
//  LOCK_STABLE   16     consecutive synced-lock-high cycles needed to leave WAIT_LOCK
//  LOCK_TIMEOUT  65536  max cycles in WAIT_LOCK before a retry
//  SYNC_CYCLES   16     user_sync pulse width (>=1)
//  MAX_RETRY     3      lock timeouts tolerated before ERROR (1..3)
// PORTS
//  clk          in   1   system clock; every register is on this clock
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   level; sampled only in IDLE and ERROR
//  pll_locked   in   1   from ads5404_top, asynchronous; 2-flop synchronised internally
//  cfg_tap_a    in   5   IDELAY tap for ADC A lanes (ctrl bits 0..15)
//  cfg_tap_b    in   5   IDELAY tap for ADC B lanes (ctrl bits 16..31)
//  user_rst     out  1   to ads5404_top user_rst
//  user_sync    out  1   to ads5404_top user_sync
//  user_enable  out  1   to ads5404_top user_enable
//  idelay_val   out  32  {27'b0, tap}, tap = lane<16 ? cfg_tap_a : cfg_tap_b
//  idelay_ctrl  out  32  one-hot lane load strobe
//  ready        out  1   high only in RUN
//  error        out  1   high only in ERROR
//  lock_lost    out  1   sticky: set on lock loss in RUN; cleared by rst or by accepted start
//  retry_cnt    out  2   lock timeouts in the current bring-up attempt
//  state        out  3   IDLE=0 RESET=1 WAIT_LOCK=2 LOAD_DLY=3 SYNC=4 RUN=5 ERROR=6
// BEHAVIOUR
//  Reset values: state=IDLE, user_rst=1, user_sync=0, user_enable=0, idelay_val=0, idelay_ctrl=0,
//   ready=0, error=0, lock_lost=0, retry_cnt=0, all counters=0.
//  All outputs are registered. Each value below applies from the first cycle in the state.
//  user_rst=1 in IDLE, RESET, ERROR; 0 otherwise. user_enable=1 in every state except IDLE/ERROR.
//  IDLE: start=1 -> RESET; clear retry_cnt and lock_lost.
//  RESET: hold exactly RST_CYCLES cycles -> WAIT_LOCK; clear timeout and stable counters.
//  WAIT_LOCK: stable counter increments while lk_s=1 (synchronised lock); resets to 0 when lk_s=0.
//   Stable counter reaches LOCK_STABLE -> LOAD_DLY. Lock test wins if it falls on the timeout cycle.
//   Timeout counter reaches LOCK_TIMEOUT -> retry_cnt+1; new count==MAX_RETRY -> ERROR, else RESET.
//  LOAD_DLY: lane counter runs 0..31, one lane per 2 cycles.
//   Cycle 0 of each lane: idelay_val set, idelay_ctrl=0. Cycle 1: idelay_ctrl[lane]=1.
//   The strobe is always one cycle long, with val stable the cycle before and during it.
//   After lane 31: idelay_ctrl=0 -> SYNC. Total 64 cycles. cfg_tap_* sampled per lane, not latched.
//   lk_s=0 here -> RESET; retry_cnt unchanged.
//  SYNC: user_sync=1 exactly SYNC_CYCLES cycles -> RUN. lk_s=0 -> RESET; user_sync drops next cycle.
//  RUN: ready=1; retry_cnt cleared on entry. lk_s=0 -> set lock_lost, ready=0 next cycle, -> RESET.
//  ERROR: error=1; wait for start=1 -> RESET with retry_cnt and lock_lost cleared.
//  start is ignored in RESET, WAIT_LOCK, LOAD_DLY, SYNC and RUN.
//  Async rst mid-sequence: immediate return to reset values; no strobe may stay asserted.
//  Counters are sized $clog2(param+1); no wrap-around is reachable.
// TESTING
//  1 start=1, lock high 100 cyc after user_rst falls -> LOAD_DLY, 32 single-cycle one-hot strobes,
//    16-cycle sync, ready=1, retry_cnt=0.
//  2 tap_a=5'd9, tap_b=5'd21 -> idelay_val=9 at ctrl bits 0..15, =21 at bits 16..31;
//    val stable 1 cycle before each strobe.
//  3 lock never asserts, MAX_RETRY=3, LOCK_TIMEOUT=256 -> three RESET/WAIT cycles, then
//    error=1, state=6, retry_cnt=3; start=1 -> RESET with retry_cnt=0.
//  4 lock glitches low for 1 cycle at stable count 10 -> stable counter restarts;
//    LOAD_DLY entered only after 16 clean cycles.
//  5 in RUN, drop pll_locked -> within 3 clk: ready=0, lock_lost=1, user_rst=1;
//    restore lock -> back to RUN with lock_lost still 1.
//  6 assert rst during LOAD_DLY lane 7 and during SYNC -> all outputs at reset values
//    that cycle; idelay_ctrl=0, user_sync=0.

Source files
------------

// File: rtl/ads5404_bringup_ctrl.sv
// Power-up / recovery sequencer for one ads5404_top: reset, PLL lock qualification with retry,
// per-lane IDELAY tap load, user_sync pulse, then RUN until lock is lost.
module ads5404_bringup_ctrl #(
    parameter int unsigned RST_CYCLES   = 64,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned SYNC_CYCLES  = 16,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pll_locked,
    input  logic [4:0]  cfg_tap_a,
    input  logic [4:0]  cfg_tap_b,
    output logic        user_rst,
    output logic        user_sync,
    output logic        user_enable,
    output logic [31:0] idelay_val,
    output logic [31:0] idelay_ctrl,
    output logic        ready,
    output logic        error,
    output logic        lock_lost,
    output logic [1:0]  retry_cnt,
    output logic [2:0]  state
);

    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned YW = $clog2(SYNC_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TO_MAX    = TW'(LOCK_TIMEOUT);
    localparam logic [YW-1:0] SYNC_LAST = YW'(SYNC_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [4:0]    LANE_LAST = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_SYNC  = 3'd4,
        S_RUN   = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t        st_q, st_d;
    logic          lk_meta, lk_s;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] to_q, to_d;
    logic [YW-1:0] sy_q, sy_d;
    logic [4:0]    lane_q, lane_d;
    logic          ph_q, ph_d;
    logic [1:0]    retry_d;
    logic          lock_lost_d;
    logic          user_rst_d, user_sync_d, user_enable_d, ready_d, error_d;
    logic [31:0]   idelay_val_d, idelay_ctrl_d;

    assign state = st_q;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= S_IDLE;
            rst_cnt_q   <= '0;
            stab_q      <= '0;
            to_q        <= '0;
            sy_q        <= '0;
            lane_q      <= '0;
            ph_q        <= 1'b0;
            retry_cnt   <= '0;
            lock_lost   <= 1'b0;
            user_rst    <= 1'b1;
            user_sync   <= 1'b0;
            user_enable <= 1'b0;
            ready       <= 1'b0;
            error       <= 1'b0;
            idelay_val  <= '0;
            idelay_ctrl <= '0;
        end else begin
            st_q        <= st_d;
            rst_cnt_q   <= rst_cnt_d;
            stab_q      <= stab_d;
            to_q        <= to_d;
            sy_q        <= sy_d;
            lane_q      <= lane_d;
            ph_q        <= ph_d;
            retry_cnt   <= retry_d;
            lock_lost   <= lock_lost_d;
            user_rst    <= user_rst_d;
            user_sync   <= user_sync_d;
            user_enable <= user_enable_d;
            ready       <= ready_d;
            error       <= error_d;
            idelay_val  <= idelay_val_d;
            idelay_ctrl <= idelay_ctrl_d;
        end
    end

    always_comb begin
        st_d          = st_q;
        rst_cnt_d     = rst_cnt_q;
        stab_d        = stab_q;
        to_d          = to_q;
        sy_d          = sy_q;
        lane_d        = lane_q;
        ph_d          = ph_q;
        retry_d       = retry_cnt;
        lock_lost_d   = lock_lost;
        user_rst_d    = 1'b1;
        user_sync_d   = 1'b0;
        user_enable_d = 1'b0;
        ready_d       = 1'b0;
        error_d       = 1'b0;
        idelay_val_d  = '0;
        idelay_ctrl_d = '0;

        case (st_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    st_d        = S_RESET;
                    retry_d     = '0;
                    lock_lost_d = 1'b0;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) st_d = S_WAIT;
                else rst_cnt_d = rst_cnt_q + RW'(1);
            end
            S_WAIT: begin
                // A stable lock on the timeout cycle still wins
                stab_d = lk_s ? stab_q + SW'(1) : '0;
                to_d   = to_q + TW'(1);
                if (stab_d == STAB_MAX) begin
                    st_d = S_LOAD;
                end else if (to_d == TO_MAX) begin
                    retry_d = retry_cnt + 2'd1;
                    st_d    = (retry_d == RETRY_MAX) ? S_ERROR : S_RESET;
                end
            end
            S_LOAD: begin
                if (!lk_s) begin
                    st_d = S_RESET;
                end else if (!ph_q) begin
                    ph_d = 1'b1;
                end else if (lane_q == LANE_LAST) begin
                    st_d = S_SYNC;
                end else begin
                    lane_d = lane_q + 5'd1;
                    ph_d   = 1'b0;
                end
            end
            S_SYNC: begin
                if (!lk_s) st_d = S_RESET;
                else if (sy_q == SYNC_LAST) st_d = S_RUN;
                else sy_d = sy_q + YW'(1);
            end
            S_RUN: begin
                if (!lk_s) begin
                    lock_lost_d = 1'b1;
                    st_d        = S_RESET;
                end
            end
            default: st_d = S_IDLE;
        endcase

        // Per-state counters restart on entry
        if (st_d != st_q) begin
            case (st_d)
                S_RESET: rst_cnt_d = '0;
                S_WAIT: begin
                    to_d   = '0;
                    stab_d = '0;
                end
                S_LOAD: begin
                    lane_d = '0;
                    ph_d   = 1'b0;
                end
                S_SYNC:  sy_d = '0;
                S_RUN:   retry_d = '0;
                default: ;
            endcase
        end

        user_rst_d    = (st_d == S_IDLE) || (st_d == S_RESET) || (st_d == S_ERROR);
        user_enable_d = (st_d != S_IDLE) && (st_d != S_ERROR);
        user_sync_d   = (st_d == S_SYNC);
        ready_d       = (st_d == S_RUN);
        error_d       = (st_d == S_ERROR);

        // Tap is sampled on the first cycle of a lane and held through its strobe cycle
        if (st_d == S_LOAD) begin
            if (!ph_d) begin
                idelay_val_d = {27'b0, lane_d[4] ? cfg_tap_b : cfg_tap_a};
            end else begin
                idelay_val_d  = idelay_val;
                idelay_ctrl_d = 32'(1) << lane_d;
            end
        end
    end

endmodule

// File: tb/tb_ads5404_bringup_ctrl.sv
// Directed/randomised bench for ads5404_bringup_ctrl; expected timelines derived from sequence rules.
module tb_ads5404_bringup_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pll_locked;
    logic [4:0]  cfg_tap_a, cfg_tap_b;
    logic        user_rst, user_sync, user_enable, ready, error, lock_lost;
    logic [31:0] idelay_val, idelay_ctrl;
    logic [1:0]  retry_cnt;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int exp_retry = 0;
    int exp_ll = 0;

    ads5404_bringup_ctrl #(
        .RST_CYCLES  (64),
        .LOCK_STABLE (16),
        .LOCK_TIMEOUT(256),
        .SYNC_CYCLES (16),
        .MAX_RETRY   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pll_locked (pll_locked),
        .cfg_tap_a  (cfg_tap_a),
        .cfg_tap_b  (cfg_tap_b),
        .user_rst   (user_rst),
        .user_sync  (user_sync),
        .user_enable(user_enable),
        .idelay_val (idelay_val),
        .idelay_ctrl(idelay_ctrl),
        .ready      (ready),
        .error      (error),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Outputs fully determined by the sequencer state number
    task automatic chk_outs(input string tag, input int st);
        chk({tag, ":state"},       32'(state),       32'(st));
        chk({tag, ":user_rst"},    32'(user_rst),    32'(st == 0 || st == 1 || st == 6));
        chk({tag, ":user_enable"}, 32'(user_enable), 32'(!(st == 0 || st == 6)));
        chk({tag, ":user_sync"},   32'(user_sync),   32'(st == 4));
        chk({tag, ":ready"},       32'(ready),       32'(st == 5));
        chk({tag, ":error"},       32'(error),       32'(st == 6));
        chk({tag, ":retry_cnt"},   32'(retry_cnt),   32'(exp_retry));
        chk({tag, ":lock_lost"},   32'(lock_lost),   32'(exp_ll));
        if (st != 3) chk({tag, ":idelay_ctrl"}, idelay_ctrl, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        exp_retry = 0;
        exp_ll    = 0;
        chk_outs(tag, 0);
        chk({tag, ":idelay_val"}, idelay_val, 32'd0);
    endtask

    task automatic hold(input int st, input int n);
        for (int i = 0; i < n; i++) begin
            chk_outs($sformatf("hold_s%0d_c%0d", st, i), st);
            step();
        end
    endtask

    task automatic set_taps(input logic [4:0] a, input logic [4:0] b);
        cfg_tap_a = a;
        cfg_tap_b = b;
    endtask

    // 64 cycles: lane L shows its tap on cycle 2L and its strobe on cycle 2L+1
    task automatic load_check(input bit rnd, input int abort_k);
        logic [31:0] exp_val;
        exp_val = {27'b0, cfg_tap_a};
        for (int k = 0; k < 64; k++) begin
            int lane;
            lane = k / 2;
            chk_outs($sformatf("load_k%0d", k), 3);
            chk($sformatf("load_k%0d:val", k), idelay_val, exp_val);
            chk($sformatf("load_k%0d:ctrl", k), idelay_ctrl, (k % 2 == 1) ? (32'(1) << lane) : 32'd0);
            if (k == abort_k) return;
            if (rnd) set_taps(5'($urandom), 5'($urandom));
            if (k % 2 == 1 && k < 63)
                exp_val = {27'b0, ((k + 1) / 2 < 16) ? cfg_tap_a : cfg_tap_b};
            step();
        end
    endtask

    task automatic sync_check(input int abort_i);
        for (int i = 0; i < 16; i++) begin
            chk_outs($sformatf("sync_c%0d", i), 4);
            if (i == abort_i) return;
            step();
        end
        exp_retry = 0;
        chk_outs("run_entry", 5);
    endtask

    // From the first RESET cycle to the first RUN cycle; lock_delay<0 means lock already up
    task automatic bringup(input int lock_delay, input bit rnd);
        hold(1, 64);
        if (lock_delay >= 0) begin
            hold(2, lock_delay);
            pll_locked = 1'b1;
            hold(2, 18);
        end else begin
            hold(2, 16);
        end
        load_check(rnd, -1);
        sync_check(-1);
    endtask

    // Lose lock in RUN, come back with a one-cycle synced glitch at stable count g
    task automatic glitch_recover(input int g);
        set_taps(5'($urandom), 5'($urandom));
        pll_locked = 1'b0;
        hold(5, 3);
        exp_ll = 1;
        pll_locked = 1'b1;
        hold(1, 64);
        hold(2, g - 2);
        pll_locked = 1'b0;
        hold(2, 1);
        pll_locked = 1'b1;
        hold(2, 18);
        load_check(1'b1, -1);
        sync_check(-1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pll_locked = 1'b0;
        set_taps(5'd0, 5'd0);
        @(negedge clk);
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        hold(0, 5);

        // Nominal bring-up, fixed taps, lock 100 cycles after user_rst falls
        set_taps(5'd9, 5'd21);
        start = 1'b1;
        step();
        start = 1'b0;
        bringup(100, 1'b0);

        start = 1'b1;
        hold(5, 5);
        start = 1'b0;

        // Lock loss in RUN, recovery with lock glitches
        glitch_recover(10);
        glitch_recover(int'($urandom_range(2, 14)));

        // Async reset mid LOAD_DLY (lane 7 strobe) and mid SYNC
        rst = 1'b1;
        #1;
        chk_reset("rst_run");
        @(negedge clk);
        rst = 1'b0;
        set_taps(5'($urandom), 5'($urandom));
        start = 1'b1;
        step();
        start = 1'b0;
        hold(1, 64);
        hold(2, 16);
        load_check(1'b0, 15);
        rst = 1'b1;
        #1;
        chk_reset("rst_load");
        @(negedge clk);
        chk_reset("rst_load_hold");
        rst   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        hold(1, 64);
        hold(2, 16);
        load_check(1'b1, -1);
        sync_check(5);
        rst = 1'b1;
        #1;
        chk_reset("rst_sync");
        @(negedge clk);
        rst = 1'b0;

        // Randomised lock delay from unlocked
        pll_locked = 1'b0;
        set_taps(5'($urandom), 5'($urandom));
        start = 1'b1;
        step();
        start = 1'b0;
        bringup(int'($urandom_range(0, 200)), 1'b1);

        // Lock never returns: three timeouts then ERROR; start is ignored meanwhile
        pll_locked = 1'b0;
        hold(5, 3);
        exp_ll = 1;
        start  = 1'b1;
        hold(1, 64);
        for (int t = 1; t <= 3; t++) begin
            hold(2, 256);
            start     = 1'b0;
            exp_retry = t;
            if (t < 3) hold(1, 64);
        end
        hold(6, 5);
        start = 1'b1;
        step();
        start     = 1'b0;
        exp_retry = 0;
        exp_ll    = 0;
        hold(1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
